// File: rtl/gate_op_sequencer.sv
// Classical gate-operation sequencer: queues X/CNOT/SWAP/CLR/MEAS operations in a FIFO
// and executes one per cycle against an NQ-bit register, stalling on unacknowledged snapshots.
module gate_op_sequencer #(
  parameter int NQ    = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op_code,
  input  logic [$clog2(NQ)-1:0]  op_a,
  input  logic [$clog2(NQ)-1:0]  op_b,
  output logic [NQ-1:0]          q_state,
  output logic                   meas_valid,
  output logic [NQ-1:0]          meas_data,
  input  logic                   meas_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned AW = $clog2(NQ);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_X    = 3'd1;
  localparam logic [2:0] OP_CNOT = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_MEAS = 3'd5;

  typedef enum logic {RUN, WAIT_MEAS} state_t;

  typedef struct packed {
    logic [2:0]    code;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } op_t;

  op_t           mem [DEPTH];
  op_t           head;
  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          a_ok;
  logic          b_ok;
  logic          err_set;
  logic          meas_go;
  logic          meas_valid_next;
  logic [NQ-1:0] q_next;

  assign push = op_valid && op_ready;
  assign pop  = (state == RUN) && (count != '0);
  assign head = mem[rd_ptr];
  assign a_ok = 32'(head.a) < 32'(NQ);
  assign b_ok = 32'(head.b) < 32'(NQ);

  // Operation storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {op_code, op_a, op_b};
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Execute the FIFO head against the register.
  always_comb begin
    q_next  = q_state;
    err_set = 1'b0;
    meas_go = 1'b0;
    if (pop) begin
      case (head.code)
        OP_NOP: begin end
        OP_X: begin
          if (a_ok) q_next[head.a] = ~q_state[head.a];
          else      err_set = 1'b1;
        end
        OP_CNOT: begin
          if (!a_ok || !b_ok || head.a == head.b) err_set = 1'b1;
          else q_next[head.b] = q_state[head.b] ^ q_state[head.a];
        end
        OP_SWAP: begin
          if (a_ok && b_ok) begin
            q_next[head.a] = q_state[head.b];
            q_next[head.b] = q_state[head.a];
          end else begin
            err_set = 1'b1;
          end
        end
        OP_CLR:  q_next  = '0;
        OP_MEAS: meas_go = 1'b1;
        default: err_set = 1'b1;
      endcase
    end
  end

  always_comb begin
    meas_valid_next = meas_valid;
    if (meas_go) meas_valid_next = 1'b1;
    else if (state == WAIT_MEAS && meas_ready) meas_valid_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_state    <= '0;
      meas_data  <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      op_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      q_state    <= q_next;
      meas_valid <= meas_valid_next;
      if (err_set) err <= 1'b1;
      // Flow-control flags track the post-edge occupancy so they stay registered.
      op_ready <= count_next < CW'(DEPTH);
      busy     <= (count_next != '0) || meas_valid_next;
      case (state)
        RUN: begin
          if (meas_go) begin
            meas_data <= q_state;
            state     <= WAIT_MEAS;
          end
        end
        WAIT_MEAS: begin
          if (meas_ready) state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_op_sequencer.sv
// Self-checking bench for gate_op_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_gate_op_sequencer;

  localparam int NQ    = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [1:0] op_a;
  logic [1:0] op_b;
  logic [3:0] q_state;
  logic       meas_valid;
  logic [3:0] meas_data;
  logic       meas_ready;
  logic       busy;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  gate_op_sequencer #(.NQ(NQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .q_state(q_state),
    .meas_valid(meas_valid), .meas_data(meas_data), .meas_ready(meas_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: operation queue plus register, snapshot and error flag.
  typedef struct {int code; int a; int b;} mop_t;
  mop_t       mfifo[$];
  logic [3:0] mq;
  logic [3:0] mdata;
  logic       mvalid;
  logic       merr;

  task automatic model_reset();
    mfifo.delete();
    mq = '0; mdata = '0; mvalid = 1'b0; merr = 1'b0;
  endtask

  task automatic tick();
    mop_t op;
    logic t;
    bit   do_push;
    @(posedge clk);
    if (!rst) begin
      do_push = op_valid && (mfifo.size() < DEPTH);
      if (mvalid) begin
        if (meas_ready) mvalid = 1'b0;
      end else if (mfifo.size() > 0) begin
        op = mfifo.pop_front();
        case (op.code)
          1: mq[op.a] = ~mq[op.a];
          2: if (op.a == op.b) merr = 1'b1; else mq[op.b] = mq[op.b] ^ mq[op.a];
          3: begin t = mq[op.a]; mq[op.a] = mq[op.b]; mq[op.b] = t; end
          4: mq = '0;
          5: begin mdata = mq; mvalid = 1'b1; end
          6, 7: merr = 1'b1;
          default: ;
        endcase
      end
      if (do_push) mfifo.push_back('{int'(op_code), int'(op_a), int'(op_b)});
    end
    #1;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push_op(input int code, input int a, input int b);
    int w = 0;
    op_valid = 1'b0;
    while (!op_ready && w < 20) begin tick(); w++; end
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_wait op_ready=%b want 1 after %0d cycles", op_ready, w);
    end
    op_valid = 1'b1; op_code = 3'(code); op_a = 2'(a); op_b = 2'(b);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; meas_ready = 1'b0;
    op_code = '0; op_a = '0; op_b = '0;
    model_reset();
    #22;
    n_tests++; if (q_state !== 4'b0)    begin n_fail++; $display("FAIL reset_q got %b want 0000", q_state); end
    n_tests++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mv got %b want 0", meas_valid); end
    n_tests++; if (meas_data !== 4'b0)  begin n_fail++; $display("FAIL reset_md got %b want 0000", meas_data); end
    n_tests++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (op_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got %b want 1", op_ready); end
    rst = 1'b0;
  endtask

  task automatic test_meas();
    int hi = 0;
    logic [3:0] snap = 'x;
    meas_ready = 1'b1;
    push_op(4, 0, 0); idle(2);
    push_op(1, 0, 0); push_op(1, 2, 0); push_op(5, 0, 0);
    repeat (5) begin
      tick();
      if (meas_valid === 1'b1) begin hi++; snap = meas_data; end
    end
    n_tests++; if (hi != 1)            begin n_fail++; $display("FAIL meas_pulse got %0d cycles want 1", hi); end
    n_tests++; if (snap !== 4'b0101)   begin n_fail++; $display("FAIL meas_data got %b want 0101", snap); end
    n_tests++; if (q_state !== 4'b0101) begin n_fail++; $display("FAIL meas_q got %b want 0101", q_state); end
  endtask

  task automatic test_cnot_swap();
    meas_ready = 1'b1;
    push_op(4, 0, 0); push_op(1, 0, 0); push_op(2, 0, 3); push_op(3, 0, 1);
    idle(3);
    n_tests++; if (q_state !== 4'b1010) begin n_fail++; $display("FAIL cnot_swap_q got %b want 1010", q_state); end
    n_tests++; if (err !== 1'b0)        begin n_fail++; $display("FAIL cnot_swap_err got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_q [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    meas_ready = 1'b1;
    push_op(4, 0, 0); idle(2);
    meas_ready = 1'b0;
    push_op(5, 0, 0);
    for (int i = 0; i < 4; i++) push_op(1, i, 0);
    n_tests++; if (op_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_full_ready got %b want 0", op_ready); end
    n_tests++; if (meas_valid !== 1'b1) begin n_fail++; $display("FAIL bp_mv got %b want 1", meas_valid); end
    // Offer an extra op while full; it must never be accepted.
    op_valid = 1'b1; op_code = 3'd1; op_a = 2'd0; op_b = 2'd0;
    tick();
    n_tests++; if (q_state !== 4'b0)    begin n_fail++; $display("FAIL bp_stall_q got %b want 0000", q_state); end
    n_tests++; if (meas_data !== 4'b0)  begin n_fail++; $display("FAIL bp_hold_md got %b want 0000", meas_data); end
    meas_ready = 1'b1;
    tick();
    n_tests++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_mv got %b want 0", meas_valid); end
    n_tests++; if (q_state !== 4'b0)    begin n_fail++; $display("FAIL bp_release_q got %b want 0000", q_state); end
    tick();
    op_valid = 1'b0;
    n_tests++; if (op_ready !== 1'b1)   begin n_fail++; $display("FAIL bp_pop_ready got %b want 1", op_ready); end
    n_tests++; if (q_state !== exp_q[0]) begin n_fail++; $display("FAIL bp_drain0 got %b want %b", q_state, exp_q[0]); end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy%0d got %b want 1", i, busy); end
      tick();
      n_tests++; if (q_state !== exp_q[i]) begin n_fail++; $display("FAIL bp_drain%0d got %b want %b", i, q_state, exp_q[i]); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    meas_ready = 1'b1;
    push_op(4, 0, 0); idle(2);
    op_valid = 1'b1; op_code = 3'd1; op_a = 2'd1; op_b = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d got %b want 1", k, op_ready); end
      n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL b2b_busy%0d got %b want 1", k, busy); end
      if (k >= 2) begin
        n_tests++;
        if (q_state[1] !== 1'((k - 1) & 1)) begin
          n_fail++; $display("FAIL b2b_toggle%0d got %b want %0d", k, q_state[1], (k - 1) & 1);
        end
      end
    end
    op_valid = 1'b0;
    tick();
    n_tests++; if (q_state !== 4'b0000) begin n_fail++; $display("FAIL b2b_final_q got %b want 0000", q_state); end
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL b2b_final_busy got %b want 0", busy); end
  endtask

  task automatic test_illegal();
    meas_ready = 1'b1;
    push_op(4, 0, 0); push_op(1, 3, 0); push_op(7, 0, 0); push_op(2, 1, 1);
    idle(2);
    n_tests++; if (q_state !== 4'b1000) begin n_fail++; $display("FAIL illegal_q got %b want 1000", q_state); end
    n_tests++; if (err !== 1'b1)        begin n_fail++; $display("FAIL illegal_err got %b want 1", err); end
    push_op(4, 0, 0); idle(2);
    n_tests++; if (q_state !== 4'b0000) begin n_fail++; $display("FAIL illegal_clr_q got %b want 0000", q_state); end
    n_tests++; if (err !== 1'b1)        begin n_fail++; $display("FAIL illegal_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    meas_ready = 1'b1;
    push_op(4, 0, 0); idle(2);
    push_op(1, 0, 0); push_op(1, 1, 0); push_op(1, 2, 0);
    n_tests++; if (q_state !== 4'b0011) begin n_fail++; $display("FAIL rmid_pre_q got %b want 0011", q_state); end
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (q_state !== 4'b0)  begin n_fail++; $display("FAIL rmid_q got %b want 0000", q_state); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", op_ready); end
    #10 rst = 1'b0;
    idle(3);
    n_tests++; if (q_state !== 4'b0)  begin n_fail++; $display("FAIL rmid_discard got %b want 0000", q_state); end
    push_op(1, 3, 0);
    n_tests++; if (q_state !== 4'b0)    begin n_fail++; $display("FAIL rmid_lat0 got %b want 0000", q_state); end
    tick();
    n_tests++; if (q_state !== 4'b1000) begin n_fail++; $display("FAIL rmid_lat1 got %b want 1000", q_state); end
  endtask

  task automatic test_random();
    logic [11:0] got, want;
    int c;
    #3 rst = 1'b1;
    model_reset();
    #10 rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      c = int'($urandom_range(0, 7));
      if (c == 4 && $urandom_range(0, 3) != 0) c = 1;
      op_valid   = ($urandom_range(0, 3) != 0);
      op_code    = 3'(c);
      op_a       = 2'($urandom_range(0, 3));
      op_b       = 2'($urandom_range(0, 3));
      meas_ready = ($urandom_range(0, 2) != 0);
      tick();
      got  = {q_state, meas_valid, meas_data, busy, op_ready, err};
      want = {mq, mvalid, mdata, (mfifo.size() != 0) || mvalid, mfifo.size() < DEPTH, merr};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random_cycle%0d got q/mv/md/busy/rdy/err=%b want %b", i, got, want);
      end
    end
    op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_meas();
    test_cnot_swap();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
